// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants, converter state type and blanking helper for the FND scan path
package fnd_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int MAX_VALUE  = 9999;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

  // A digit goes dark only when it and every more-significant digit are zero.
  function automatic logic digit_enable(input logic [BCD_W-1:0] digits,
                                        input logic [1:0] idx,
                                        input logic blank_lz);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && digits[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    return !(blank_lz && idx != 2'd0 && upper_zero);
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary to BCD converter, one bit per cycle
module bin_to_bcd_seq
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [BCD_W-1:0] o_bcd
);
  localparam int         SHIFT_W   = BCD_W + BIN_W;
  localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

  conv_state_t        r_state, w_next_state;
  logic [SHIFT_W-1:0] r_shift, w_adjusted;
  logic [3:0]         r_iter;

  always_comb begin
    w_adjusted = r_shift;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_shift[BIN_W + 4*i +: 4] >= 4'd5)
        w_adjusted[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_next_state = SHIFT;
      SHIFT: begin
        o_busy = 1'b1;
        if (r_iter == LAST_ITER) w_next_state = DONE;
      end
      DONE: begin
        o_busy       = 1'b1;
        o_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_iter  <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: if (i_start) begin
          r_shift <= {{BCD_W{1'b0}}, i_bin};
          r_iter  <= '0;
        end
        SHIFT: begin
          r_shift <= {w_adjusted[SHIFT_W-2:0], 1'b0};
          r_iter  <= r_iter + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd = r_shift[SHIFT_W-1 -: BCD_W];
endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - captures the input number, converts it to BCD and scans four digits
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 4000
)
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_number,
  input  logic             i_blankLZ,
  output logic [1:0]       o_digitSelect,
  output logic [3:0]       o_value,
  output logic             o_en,
  output logic             o_overflow,
  output logic             o_busy
);
  localparam int               DIV      = CLK_HZ / SCAN_HZ;
  localparam int               CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_VALUE);

  logic [BIN_W-1:0] r_last;
  logic             r_cap_ovf;
  logic [BCD_W-1:0] r_disp;
  logic             r_disp_ovf;
  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_index;

  logic             w_busy, w_done, w_start, w_ovf;
  logic [BIN_W-1:0] w_sat;
  logic [BCD_W-1:0] w_bcd;

  // The raw input is remembered, so a held out-of-range value does not retrigger conversions.
  assign w_ovf   = i_number > MAX_BIN;
  assign w_sat   = w_ovf ? MAX_BIN : i_number;
  assign w_start = !w_busy && (i_number != r_last);
  assign o_busy  = w_busy;

  bin_to_bcd_seq u_conv (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (w_start),
    .i_bin   (w_sat),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last     <= '0;
      r_cap_ovf  <= 1'b0;
      r_disp     <= '0;
      r_disp_ovf <= 1'b0;
    end else begin
      if (w_start) begin
        r_last    <= i_number;
        r_cap_ovf <= w_ovf;
      end
      if (w_done) begin
        r_disp     <= w_bcd;
        r_disp_ovf <= r_cap_ovf;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_scan_cnt <= '0;
      r_index    <= '0;
    end else if (r_scan_cnt == CNT_LAST) begin
      r_scan_cnt <= '0;
      r_index    <= r_index + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_digitSelect <= '0;
      o_value       <= '0;
      o_en          <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      o_digitSelect <= r_index;
      o_value       <= r_disp[{r_index, 2'b00} +: 4];
      o_en          <= digit_enable(r_disp, r_index, i_blankLZ);
      o_overflow    <= r_disp_ovf;
    end
  end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb/tb_fnd_scan_controller.sv - self-checking bench with a decimal-arithmetic display model
module tb_fnd_scan_controller;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] num;
  logic        blank;
  logic [1:0]  sel;
  logic [3:0]  val;
  logic        en, ovf, busy;

  always #5 clk = ~clk;

  fnd_scan_controller #(.CLK_HZ(16), .SCAN_HZ(4)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_number      (num),
    .i_blankLZ     (blank),
    .o_digitSelect (sel),
    .o_value       (val),
    .o_en          (en),
    .o_overflow    (ovf),
    .o_busy        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_last, m_cnt, m_cap, m_disp, m_tick, m_idx;
  bit m_capovf, m_dovf;
  bit m_valid = 1'b0;
  int e_sel, e_val;
  bit e_en, e_ovf, e_busy;

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a conversion is a 15-cycle countdown after capture; digits come from decimal arithmetic.
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_last = 0; m_cnt = 0; m_cap = 0; m_disp = 0; m_tick = 0; m_idx = 0;
      m_capovf = 1'b0; m_dovf = 1'b0;
      e_sel = 0; e_val = 0; e_en = 1'b0; e_ovf = 1'b0;
    end else begin
      e_sel = m_idx;
      e_val = (m_disp / pow10(m_idx)) % 10;
      e_en  = !(blank && m_idx > 0 && m_disp < pow10(m_idx));
      e_ovf = m_dovf;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_disp = m_cap;
          m_dovf = m_capovf;
        end
      end else if (int'(num) != m_last) begin
        m_last   = int'(num);
        m_capovf = int'(num) > 9999;
        m_cap    = m_capovf ? 9999 : int'(num);
        m_cnt    = 15;
      end
      m_tick++;
      if (m_tick == DIV) begin
        m_tick = 0;
        m_idx  = (m_idx + 1) % 4;
      end
    end
    e_busy = m_cnt > 0;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_sel",  int'(sel),  e_sel);
      check("model_val",  int'(val),  e_val);
      check("model_en",   int'(en),   int'(e_en));
      check("model_ovf",  int'(ovf),  int'(e_ovf));
      check("model_busy", int'(busy), int'(e_busy));
    end
  end

  task automatic wait_busy(input logic level, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy == level) break;
      @(negedge clk);
    end
    check("busy_wait", int'(busy), int'(level));
  endtask

  task automatic check_digit(input int idx, input int exp_val, input int exp_en);
    for (int i = 0; i < 2 * 4 * DIV; i++) begin
      @(negedge clk);
      if (int'(sel) == idx) break;
    end
    check($sformatf("digit%0d_sel", idx), int'(sel), idx);
    check($sformatf("digit%0d_val", idx), int'(val), exp_val);
    check($sformatf("digit%0d_en", idx),  int'(en),  exp_en);
  endtask

  task automatic convert(input int n);
    num = 14'(n);
    wait_busy(1'b1, 8);
    wait_busy(1'b0, 24);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cnt;
    int d5678[4];
    d5678 = '{8, 7, 6, 5};
    rst = 1'b1; num = '0; blank = 1'b0;

    // 1: reset state and scan stepping
    repeat (3) @(negedge clk);
    check("rst_en", int'(en), 0);
    check("rst_sel", int'(sel), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_en", int'(en), 1);
    check("post_rst_sel", int'(sel), 0);
    check("post_rst_val", int'(val), 0);
    repeat (4) @(negedge clk);
    check("sel_step", int'(sel), 1);

    // 2: 1234, busy length and digits
    num = 14'd1234;
    wait_busy(1'b1, 8);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("busy_len", cnt, 15);
    repeat (2) @(negedge clk);
    check_digit(0, 4, 1); check_digit(1, 3, 1); check_digit(2, 2, 1); check_digit(3, 1, 1);

    // 3: leading-zero blanking
    blank = 1'b1;
    convert(7);
    check_digit(0, 7, 1); check_digit(1, 0, 0); check_digit(2, 0, 0); check_digit(3, 0, 0);
    convert(1005);
    check_digit(0, 5, 1); check_digit(1, 0, 1); check_digit(2, 0, 1); check_digit(3, 1, 1);

    // 4: saturation then recovery
    blank = 1'b0;
    convert(12000);
    check("ovf_set", int'(ovf), 1);
    check_digit(0, 9, 1); check_digit(1, 9, 1); check_digit(2, 9, 1); check_digit(3, 9, 1);
    convert(42);
    check("ovf_clr", int'(ovf), 0);
    check_digit(0, 2, 1); check_digit(1, 4, 1); check_digit(2, 0, 1); check_digit(3, 0, 1);

    // 5: input change mid-conversion
    num = 14'd5678;
    wait_busy(1'b1, 8);
    repeat (4) @(negedge clk);
    num = 14'd1111;
    wait_busy(1'b0, 24);
    @(negedge clk);
    check("first_value", int'(val), d5678[sel]);
    wait_busy(1'b1, 4);
    wait_busy(1'b0, 24);
    repeat (2) @(negedge clk);
    check_digit(0, 1, 1); check_digit(1, 1, 1); check_digit(2, 1, 1); check_digit(3, 1, 1);

    // 6: reset pulse mid-conversion
    num = 14'd9999;
    wait_busy(1'b1, 8);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_en", int'(en), 0);
    check("midrst_val", int'(val), 0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_busy", int'(busy), 1);
    wait_busy(1'b0, 24);
    repeat (2) @(negedge clk);
    check("restart_ovf", int'(ovf), 0);
    check_digit(0, 9, 1); check_digit(1, 9, 1); check_digit(2, 9, 1); check_digit(3, 9, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
